// File: rtl/cflog_tx_sequencer.sv
// Streams LEN CFLog words to omsp_uart as MSB-first byte pairs after an acfa_nmi trigger.
// Optional checksum trailer byte when CFLOG_CHKSUM_EN is defined.
module cflog_tx_sequencer #(
  parameter int unsigned LOG_AW       = 6,
  parameter int unsigned TRIG_TIMEOUT = 32,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              puc_rst,
  input  logic              acfa_nmi,
  input  logic [LOG_AW:0]   log_len,
  output logic              read_en,
  output logic [LOG_AW-1:0] read_addr,
  input  logic [15:0]       read_val,
  output logic              data_tx_wr,
  output logic [7:0]        tx_byte,
  input  logic              tx_triggered,
  input  logic              txfer_done,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam int unsigned LEN_W = LOG_AW + 1;
  localparam int unsigned DEPTH = 2 ** LOG_AW;
  localparam int unsigned TMR_W = $clog2(TRIG_TIMEOUT + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TRIG_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_LOAD,
    S_STROBE,
    S_WTRIG,
    S_WDONE,
    S_NEXT,
`ifdef CFLOG_CHKSUM_EN
    S_CHK,
`endif
    S_FIN
  } state_t;

  // State entered once the word stream is exhausted (trailer or finish)
`ifdef CFLOG_CHKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_FIN;
`endif

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LOG_AW-1:0] addr_q, addr_d;
  logic [15:0]       word_q, word_d;
  logic              hi_q, hi_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
`ifdef CFLOG_CHKSUM_EN
  logic [7:0]        xor_q, xor_d;
  logic              trailer_q, trailer_d;
`endif

  // State register and datapath flops
  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      hi_q      <= 1'b0;
      timer_q   <= '0;
      retry_q   <= '0;
      tx_byte_q <= '0;
      rd_en_q   <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      hi_q      <= hi_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      tx_byte_q <= tx_byte_d;
      rd_en_q   <= rd_en_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

`ifdef CFLOG_CHKSUM_EN
  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      xor_q     <= '0;
      trailer_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      trailer_q <= trailer_d;
    end
  end
`endif

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    word_d    = word_q;
    hi_d      = hi_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    tx_byte_d = tx_byte_q;
    abort_d   = 1'b0;
`ifdef CFLOG_CHKSUM_EN
    xor_d     = xor_q;
    trailer_d = trailer_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (acfa_nmi) begin
          len_d   = (log_len > DEPTH_L) ? DEPTH_L : log_len;
          cnt_d   = '0;
          addr_d  = '0;
          state_d = S_RD;
`ifdef CFLOG_CHKSUM_EN
          xor_d     = '0;
          trailer_d = 1'b0;
`endif
        end
      end
      S_RD:   state_d = (len_q == '0) ? S_TAIL : S_RDW;
      S_RDW: begin
        word_d  = read_val;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        hi_d      = 1'b1;
        retry_d   = '0;
        tx_byte_d = word_q[15:8];
        state_d   = S_STROBE;
      end
      S_STROBE: begin
        timer_d = '0;
        state_d = S_WTRIG;
      end
      S_WTRIG: begin
        // A late tx_triggered always wins over the timeout in the same cycle
        if (tx_triggered) begin
          state_d = txfer_done ? S_NEXT : S_WDONE;
        end else if (timer_q == TMR_LAST) begin
          if (retry_q == RTY_MAX) begin
            abort_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_STROBE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WDONE: begin
        if (txfer_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        retry_d = '0;
`ifdef CFLOG_CHKSUM_EN
        if (!trailer_q) xor_d = xor_q ^ tx_byte_q;
        if (trailer_q) state_d = S_FIN;
        else
`endif
        if (hi_q) begin
          hi_d      = 1'b0;
          tx_byte_d = word_q[7:0];
          state_d   = S_STROBE;
        end else begin
          cnt_d   = cnt_q + LEN_W'(1);
          addr_d  = addr_q + LOG_AW'(1);
          state_d = (cnt_d == len_q) ? S_TAIL : S_RD;
        end
      end
`ifdef CFLOG_CHKSUM_EN
      S_CHK: begin
        trailer_d = 1'b1;
        retry_d   = '0;
        tx_byte_d = xor_q;
        state_d   = S_STROBE;
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered strobes line up with the state they belong to
    rd_en_d = (state_d == S_RD) && (len_d != '0);
    wr_d    = (state_d == S_STROBE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
  end

  assign read_en    = rd_en_q;
  assign read_addr  = addr_q;
  assign data_tx_wr = wr_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_cflog_tx_sequencer.sv
// Randomized bench for cflog_tx_sequencer with a UART responder and a byte-stream reference model.
module tb_cflog_tx_sequencer;

  localparam int DEPTH = 64;
`ifdef CFLOG_CHKSUM_EN
  localparam int TRAILER = 1;
`else
  localparam int TRAILER = 0;
`endif

  logic        clk = 1'b0;
  logic        puc_rst, acfa_nmi;
  logic [6:0]  log_len;
  logic        read_en;
  logic [5:0]  read_addr;
  logic [15:0] read_val;
  logic        data_tx_wr;
  logic [7:0]  tx_byte;
  logic        tx_triggered, txfer_done;
  logic        busy, done, abort;

  cflog_tx_sequencer dut (
    .clk(clk), .puc_rst(puc_rst), .acfa_nmi(acfa_nmi), .log_len(log_len),
    .read_en(read_en), .read_addr(read_addr), .read_val(read_val),
    .data_tx_wr(data_tx_wr), .tx_byte(tx_byte),
    .tx_triggered(tx_triggered), .txfer_done(txfer_done),
    .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [DEPTH];

  // Monitor logs
  int          strobe_cyc[$];
  logic [7:0]  strobe_byte[$];
  int          rd_log[$];
  int          done_cnt = 0, abort_cnt = 0, done_cyc = 0, abort_cyc = 0;
  int          busy_rise_cyc = 0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    if (data_tx_wr === 1'b1) begin
      strobe_cyc.push_back(cyc);
      strobe_byte.push_back(tx_byte);
    end
    if (read_en === 1'b1) rd_log.push_back(int'(read_addr));
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (abort === 1'b1) begin abort_cnt++; abort_cyc = cyc; end
    if (busy === 1'b1 && !busy_prev) busy_rise_cyc = cyc;
    busy_prev = (busy === 1'b1);
  end

  // Synchronous CFLog memory: data appears the cycle after read_en
  logic [5:0] mem_ra;
  initial begin
    read_val = '0;
    forever begin
      @(posedge clk);
      if (read_en === 1'b1) begin
        mem_ra = read_addr;
        #1;
        read_val = mem[mem_ra];
      end
    end
  end

  // UART responder: random trigger/done delays, can ignore strobes or stall done
  int         resp_seen = 0;
  int         ignore_upto = 0;
  bit         hold_done = 1'b0;
  logic [7:0] acc_byte[$];
  int         last_done_cyc = 0;
  int         unstable_cnt = 0;
  int         d1, d2;
  logic [7:0] sb;

  initial begin
    tx_triggered = 1'b0;
    txfer_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (data_tx_wr === 1'b1 && puc_rst === 1'b0) begin
        resp_seen++;
        if (resp_seen > ignore_upto) begin
          sb = tx_byte;
          d1 = $urandom_range(1, 3);
          d2 = $urandom_range(0, 3);
          repeat (d1) @(posedge clk);
          #1;
          if (tx_byte !== sb) unstable_cnt++;
          acc_byte.push_back(tx_byte);
          tx_triggered = 1'b1;
          txfer_done   = (d2 == 0) && !hold_done;
          if (txfer_done) last_done_cyc = cyc;
          @(posedge clk); #1;
          tx_triggered = 1'b0;
          txfer_done   = 1'b0;
          if (hold_done) begin
            while (hold_done) begin @(posedge clk); #1; end
          end else if (d2 != 0) begin
            for (int k = 1; k < d2; k++) begin @(posedge clk); #1; end
            if (tx_byte !== sb) unstable_cnt++;
            txfer_done    = 1'b1;
            last_done_cyc = cyc;
            @(posedge clk); #1;
            txfer_done = 1'b0;
          end
        end
      end
    end
  end

  // Reference: expected byte stream is the first min(len,DEPTH) words, MSB first, plus optional XOR
  function automatic int byte_diffs(int base, int len);
    logic [7:0] exp_q[$];
    logic [15:0] w;
    logic [7:0] x;
    int n, d;
    n = (len > DEPTH) ? DEPTH : len;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = mem[i];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
    end
    if (TRAILER != 0) exp_q.push_back(x);
    d = 0;
    if (int'(acc_byte.size()) - base != exp_q.size()) d++;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= acc_byte.size() || acc_byte[base + i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic int read_diffs(int base, int len);
    int n, d;
    n = (len > DEPTH) ? DEPTH : len;
    d = 0;
    if (int'(rd_log.size()) - base != n) d++;
    for (int i = 0; i < n; i++)
      if (base + i >= rd_log.size() || rd_log[base + i] != i) d++;
    return d;
  endfunction

  task automatic run_xfer(input int len, input int nmi_again, output int start, output bit to);
    int bd, ba;
    bd = done_cnt;
    ba = abort_cnt;
    to = 1'b1;
    @(posedge clk); #1;
    start    = cyc;
    log_len  = 7'(len);
    acfa_nmi = 1'b1;
    for (int k = 1; k <= 6000; k++) begin
      @(posedge clk); #1;
      acfa_nmi = (k == nmi_again);
      if (done_cnt != bd || abort_cnt != ba) begin to = 1'b0; break; end
    end
    acfa_nmi = 1'b0;
  endtask

  task automatic test_reset;
    puc_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort); end
    checks++; if (data_tx_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", data_tx_wr); end
    checks++; if (read_en !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", read_en); end
    checks++; if (read_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", read_addr); end
    @(posedge clk); #1;
    puc_rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single;
    int bs, bd, st, d;
    bit to;
    mem[0] = 16'hABCD;
    bs = acc_byte.size();
    d  = strobe_cyc.size();
    bd = done_cnt;
    run_xfer(1, 0, st, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL t1_timeout: no done within budget"); end
    checks++; if (byte_diffs(bs, 1) !== 0) begin errors++; $display("FAIL t1_bytes: %0d differences, want 0", byte_diffs(bs, 1)); end
    checks++; if (strobe_cyc.size() <= d || strobe_cyc[d] !== st + 4) begin errors++; $display("FAIL t1_latency: first strobe cycle %0d want %0d", (strobe_cyc.size() > d) ? strobe_cyc[d] : -1, st + 4); end
    checks++; if (done_cnt - bd !== 1) begin errors++; $display("FAIL t1_done_count: got %0d want 1", done_cnt - bd); end
    checks++; if (done_cyc !== last_done_cyc + 2) begin errors++; $display("FAIL t1_done_cycle: got %0d want %0d", done_cyc, last_done_cyc + 2); end
    checks++; if (busy_rise_cyc !== st + 1) begin errors++; $display("FAIL t1_busy_rise: got %0d want %0d", busy_rise_cyc, st + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_three;
    int bs, br, bd, st;
    bit to;
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
    bs = acc_byte.size(); br = rd_log.size(); bd = done_cnt;
    run_xfer(3, 0, st, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL t2_timeout: no done within budget"); end
    checks++; if (byte_diffs(bs, 3) !== 0) begin errors++; $display("FAIL t2_bytes: %0d differences, want 0", byte_diffs(bs, 3)); end
    checks++; if (read_diffs(br, 3) !== 0) begin errors++; $display("FAIL t2_reads: %0d differences, want 0", read_diffs(br, 3)); end
    checks++; if (done_cnt - bd !== 1) begin errors++; $display("FAIL t2_done_count: got %0d want 1", done_cnt - bd); end
  endtask

  task automatic test_zero;
    int bs, br, bstr, st, exp_done;
    bit to;
    bs = acc_byte.size(); br = rd_log.size(); bstr = strobe_cyc.size();
    run_xfer(0, 0, st, to);
    exp_done = (TRAILER != 0) ? last_done_cyc + 2 : st + 2;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL t3_timeout: no done within budget"); end
    checks++; if (int'(rd_log.size()) - br !== 0) begin errors++; $display("FAIL t3_reads: got %0d want 0", int'(rd_log.size()) - br); end
    checks++; if (int'(strobe_cyc.size()) - bstr !== TRAILER) begin errors++; $display("FAIL t3_strobes: got %0d want %0d", int'(strobe_cyc.size()) - bstr, TRAILER); end
    checks++; if (byte_diffs(bs, 0) !== 0) begin errors++; $display("FAIL t3_bytes: %0d differences, want 0", byte_diffs(bs, 0)); end
    checks++; if (done_cyc !== exp_done) begin errors++; $display("FAIL t3_done_cycle: got %0d want %0d", done_cyc, exp_done); end
  endtask

  task automatic test_retry;
    int bs, b, bd, st;
    bit to;
    mem[0] = 16'($urandom);
    bs = acc_byte.size(); b = strobe_cyc.size(); bd = done_cnt;
    ignore_upto = resp_seen + 1;
    run_xfer(1, 0, st, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL t4_timeout: no done within budget"); end
    checks++; if (int'(strobe_cyc.size()) - b !== 3 + TRAILER) begin errors++; $display("FAIL t4_strobes: got %0d want %0d", int'(strobe_cyc.size()) - b, 3 + TRAILER); end
    checks++; if (strobe_cyc.size() < b + 2 || strobe_cyc[b + 1] - strobe_cyc[b] !== 33) begin errors++; $display("FAIL t4_restrobe_gap: got %0d want 33", (strobe_cyc.size() >= b + 2) ? strobe_cyc[b + 1] - strobe_cyc[b] : -1); end
    checks++; if (strobe_byte.size() < b + 2 || strobe_byte[b + 1] !== strobe_byte[b]) begin errors++; $display("FAIL t4_restrobe_byte: second strobe byte differs from first"); end
    checks++; if (byte_diffs(bs, 1) !== 0) begin errors++; $display("FAIL t4_bytes: %0d differences, want 0", byte_diffs(bs, 1)); end
    checks++; if (done_cnt - bd !== 1) begin errors++; $display("FAIL t4_done_count: got %0d want 1", done_cnt - bd); end
  endtask

  task automatic test_abort;
    int b, bd, ba, st, n;
    bit to;
    b = strobe_cyc.size(); bd = done_cnt; ba = abort_cnt;
    ignore_upto = resp_seen + 1000;
    run_xfer(2, 0, st, to);
    n = int'(strobe_cyc.size()) - b;
    checks++; if (abort_cnt - ba !== 1) begin errors++; $display("FAIL t4_abort_count: got %0d want 1", abort_cnt - ba); end
    checks++; if (done_cnt - bd !== 0) begin errors++; $display("FAIL t4_abort_done: got %0d want 0", done_cnt - bd); end
    checks++; if (n !== 4) begin errors++; $display("FAIL t4_abort_strobes: got %0d want 4", n); end
    checks++; if (n < 1 || abort_cyc !== strobe_cyc[b + n - 1] + 33) begin errors++; $display("FAIL t4_abort_cycle: got %0d want %0d", abort_cyc, (n >= 1) ? strobe_cyc[b + n - 1] + 33 : -1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_abort_busy: got %b want 0", busy); end
    ignore_upto = resp_seen;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_busy_ignore;
    int bs, br, bd, b, st;
    bit to;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    bs = acc_byte.size(); br = rd_log.size(); bd = done_cnt;
    run_xfer(127, 20, st, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL t5_timeout: no done within budget"); end
    checks++; if (int'(rd_log.size()) - br !== DEPTH) begin errors++; $display("FAIL t5_read_count: got %0d want %0d", int'(rd_log.size()) - br, DEPTH); end
    checks++; if (byte_diffs(bs, 127) !== 0) begin errors++; $display("FAIL t5_bytes: %0d differences, want 0", byte_diffs(bs, 127)); end
    checks++; if (done_cnt - bd !== 1) begin errors++; $display("FAIL t5_done_count: got %0d want 1", done_cnt - bd); end
    b = strobe_cyc.size();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (int'(strobe_cyc.size()) !== b) begin errors++; $display("FAIL t5_no_requeue: %0d extra strobes, want 0", int'(strobe_cyc.size()) - b); end
  endtask

  task automatic test_random;
    int bs, br, bd, ba, bu, st, len;
    bit to;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
      len = $urandom_range(0, 70);
      bs = acc_byte.size(); br = rd_log.size(); bd = done_cnt; ba = abort_cnt; bu = unstable_cnt;
      run_xfer(len, 0, st, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd_timeout: len %0d no done within budget", len); end
      checks++; if (byte_diffs(bs, len) !== 0) begin errors++; $display("FAIL rnd_bytes: len %0d %0d differences, want 0", len, byte_diffs(bs, len)); end
      checks++; if (read_diffs(br, len) !== 0) begin errors++; $display("FAIL rnd_reads: len %0d %0d differences, want 0", len, read_diffs(br, len)); end
      checks++; if (done_cnt - bd !== 1 || abort_cnt - ba !== 0) begin errors++; $display("FAIL rnd_pulses: done %0d abort %0d, want 1 and 0", done_cnt - bd, abort_cnt - ba); end
      checks++; if (unstable_cnt - bu !== 0) begin errors++; $display("FAIL rnd_tx_byte_stable: %0d changes, want 0", unstable_cnt - bu); end
    end
  endtask

  task automatic test_reset_mid;
    int bd, ba, bs, br, st;
    bit to;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    bd = done_cnt; ba = acc_byte.size();
    hold_done = 1'b1;
    @(posedge clk); #1;
    log_len = 7'd4; acfa_nmi = 1'b1;
    @(posedge clk); #1;
    acfa_nmi = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (acc_byte.size() > ba) begin to = 1'b0; break; end
    end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL t6_no_trigger: first byte never accepted"); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy_wdone: got %b want 1", busy); end
    puc_rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, abort, data_tx_wr, read_en} !== 5'b0 || read_addr !== 6'd0) begin errors++; $display("FAIL t6_outputs: busy %b done %b abort %b wr %b rd %b addr %0d, want all 0", busy, done, abort, data_tx_wr, read_en, read_addr); end
    repeat (2) @(posedge clk);
    #1;
    puc_rst   = 1'b0;
    hold_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_cnt - bd !== 0) begin errors++; $display("FAIL t6_no_done: got %0d want 0", done_cnt - bd); end
    bs = acc_byte.size(); br = rd_log.size();
    run_xfer(2, 0, st, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL t6_restart_timeout: no done within budget"); end
    checks++; if (read_diffs(br, 2) !== 0) begin errors++; $display("FAIL t6_restart_reads: %0d differences, want 0", read_diffs(br, 2)); end
    checks++; if (byte_diffs(bs, 2) !== 0) begin errors++; $display("FAIL t6_restart_bytes: %0d differences, want 0", byte_diffs(bs, 2)); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    puc_rst  = 1'b1;
    acfa_nmi = 1'b0;
    log_len  = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_three();
    test_zero();
    test_retry();
    test_abort();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
